// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/fullsub_cell.sv
// One-bit full subtractor: computes a - b - bin, giving a difference bit and a borrow-out.
module fullsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell stepped LSB first over WIDTH cycles,
// with operand/result shift registers, a borrow register and a one-cycle done pulse.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             bout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_shift;

    fullsub_cell u_cell (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .bin (borrow_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // The new difference bit enters at the MSB; a 1-bit result has nothing to shift along.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = cell_d;
        end else begin : g_res_wn
            assign res_shift = {cell_d, res_sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                borrow_d = cell_bo;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift;
                cnt_d    = cnt_q + 1'b1;
                // Published outputs move only here, so partial results never show.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = cell_bo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign difference = diff_q;
    assign bout       = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8, 1 and 3: expected results are queued at accept
// and compared (value, borrow, latency) whenever a done pulse appears.
module tb_serial_sub_ctrl;

    typedef struct {
        int          acc;
        logic [31:0] diff;
        logic        bout;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       start8 = 1'b0, start1 = 1'b0, start3 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic [2:0] a3 = '0, b3 = '0, diff3;
    logic       busy8, done8, bout8, busy1, done1, bout1, busy3, done3, bout3;

    sb_t q8[$], q1[$], q3[$];
    sb_t e8, e1, e3;
    int  dcnt8 = 0;
    int  last_done8 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .difference(diff8), .bout(bout8)
    );
    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .difference(diff1), .bout(bout1)
    );
    serial_sub_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .difference(diff3), .bout(bout3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done8) begin
            dcnt8++;
            last_done8 = cyc;
            if (q8.size() == 0) begin
                check("done8_unexpected", 1, 0);
            end else begin
                e8 = q8.pop_front();
                check("diff8", 64'(diff8), 64'(e8.diff[7:0]));
                check("bout8", 64'(bout8), 64'(e8.bout));
                check("lat8", 64'(cyc - e8.acc), 64'd8);
                $display("w8 result diff=%02h bout=%0d at cycle %0d", diff8, bout8, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("diff1", 64'(diff1), 64'(e1.diff[0:0]));
                check("bout1", 64'(bout1), 64'(e1.bout));
                check("lat1", 64'(cyc - e1.acc), 64'd1);
                $display("w1 result diff=%0d bout=%0d at cycle %0d", diff1, bout1, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done3) begin
            if (q3.size() == 0) begin
                check("done3_unexpected", 1, 0);
            end else begin
                e3 = q3.pop_front();
                check("diff3", 64'(diff3), 64'(e3.diff[2:0]));
                check("bout3", 64'(bout3), 64'(e3.bout));
                check("lat3", 64'(cyc - e3.acc), 64'd3);
                $display("w3 result diff=%0d bout=%0d at cycle %0d", diff3, bout3, cyc);
            end
        end
    end

    // Drive one start pulse on the 8-bit instance and queue the reference result.
    task automatic op_start8(input logic [7:0] a, input logic [7:0] b);
        sb_t s;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        s.acc  = cyc;
        s.diff = 32'((a - b) & 8'hFF);
        s.bout = (a < b);
        q8.push_back(s);
        $display("w8 start a=%02h b=%02h at cycle %0d", a, b, cyc);
    endtask

    task automatic wait8();
        for (int k = 0; k < 40 && q8.size() != 0; k++) @(negedge clk);
        check("wait8_timeout", 64'(q8.size()), 0);
    endtask

    initial begin
        sb_t s;
        int  dc0;
        int  first_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy8), 0);
        check("rst_done", 64'(done8), 0);
        check("rst_diff", 64'(diff8), 0);
        check("rst_bout", 64'(bout8), 0);

        // Basic operation with explicit busy window and one-cycle done
        op_start8(8'h5A, 8'h23);
        for (int i = 0; i < 8; i++) begin
            check("t1_busy", 64'(busy8), 1);
            check("t1_nodone", 64'(done8), 0);
            @(negedge clk);
        end
        check("t1_busy_end", 64'(busy8), 0);
        check("t1_done", 64'(done8), 1);
        @(negedge clk);
        check("t1_done_pulse", 64'(done8), 0);

        // Borrow-out and equal operands
        op_start8(8'h00, 8'h01);
        wait8();
        op_start8(8'h80, 8'h80);
        wait8();
        @(negedge clk);

        // Start during SHIFT is ignored
        dc0 = dcnt8;
        op_start8(8'h10, 8'h01);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait8();
        repeat (12) @(negedge clk);
        check("t3_done_count", 64'(dcnt8 - dc0), 1);

        // Back-to-back restart from DONE with start held high
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        s.acc = cyc; s.diff = 32'h22; s.bout = 1'b0;
        q8.push_back(s);
        a8 = 8'h09; b8 = 8'h0A;
        for (int k = 0; k < 20 && !done8; k++) @(negedge clk);
        check("t4_first_done", 64'(done8), 1);
        first_done = cyc;
        @(negedge clk);
        s.acc = cyc; s.diff = 32'hFF; s.bout = 1'b1;
        q8.push_back(s);
        start8 = 1'b0;
        check("t4_no_idle", 64'(busy8), 1);
        wait8();
        check("t4_separation", 64'(last_done8 - first_done), 9);

        // Reset in the middle of an operation
        repeat (2) @(negedge clk);
        op_start8(8'hC3, 8'h41);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 64'(busy8), 0);
        check("t5_done", 64'(done8), 0);
        check("t5_diff", 64'(diff8), 0);
        check("t5_bout", 64'(bout8), 0);
        q8.delete();
        dc0 = dcnt8;
        repeat (15) @(negedge clk);
        check("t5_no_done", 64'(dcnt8 - dc0), 0);

        // Exhaustive WIDTH=1
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                a1 = 1'(i); b1 = 1'(j); start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                s.acc = cyc; s.diff = 32'((i - j) & 1); s.bout = (i < j);
                q1.push_back(s);
                $display("w1 start a=%0d b=%0d at cycle %0d", i, j, cyc);
                for (int k = 0; k < 10 && q1.size() != 0; k++) @(negedge clk);
                check("wait1_timeout", 64'(q1.size()), 0);
            end
        end

        // Exhaustive WIDTH=3
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                a3 = 3'(i); b3 = 3'(j); start3 = 1'b1;
                @(negedge clk);
                start3 = 1'b0;
                s.acc = cyc; s.diff = 32'((i - j) & 7); s.bout = (i < j);
                q3.push_back(s);
                $display("w3 start a=%0d b=%0d at cycle %0d", i, j, cyc);
                for (int k = 0; k < 10 && q3.size() != 0; k++) @(negedge clk);
                check("wait3_timeout", 64'(q3.size()), 0);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
